// File: rtl/coin_accumulator.sv
// rtl/coin_accumulator.sv - coin credit collector with offer handshake and refund
// Accepts coin pulses into a 3-bit credit, offers it on confirm, refunds on cancel/idle timeout.
module coin_accumulator #(
  parameter int MAX_CREDIT  = 7,
  parameter int TIMEOUT_CYC = 20,
  parameter int TO_W        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_in,
  input  logic [1:0] coin_val,
  input  logic       confirm,
  input  logic       cancel,
  input  logic       vend_ack,
  output logic [2:0] money,
  output logic       money_valid,
  output logic [2:0] credit,
  output logic       coin_reject,
  output logic       refund_valid,
  output logic [2:0] refund_amt
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OFFER, S_REFUND} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]      MAX_SUM = 4'(MAX_CREDIT);

  state_t          state_q, state_d;
  logic [2:0]      credit_q, credit_d;
  logic [2:0]      money_q, money_d;
  logic            money_valid_q, money_valid_d;
  logic            coin_reject_q, coin_reject_d;
  logic            refund_valid_q, refund_valid_d;
  logic [2:0]      refund_amt_q, refund_amt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic [2:0] coin_amt;
  logic [3:0] sum;
  logic       coin_ok;

  always_comb begin
    coin_amt = 3'd0;
    case (coin_val)
      2'b00:   coin_amt = 3'd1;
      2'b01:   coin_amt = 3'd2;
      2'b10:   coin_amt = 3'd5;
      default: coin_amt = 3'd0;
    endcase
    sum     = {1'b0, credit_q} + {1'b0, coin_amt};
    coin_ok = coin_in && (coin_val != 2'b11) && (sum <= MAX_SUM);
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    money_d        = money_q;
    money_valid_d  = money_valid_q;
    coin_reject_d  = 1'b0;
    refund_valid_d = 1'b0;
    refund_amt_d   = 3'd0;
    // Counter only runs in COLLECT; every exit path leaves it cleared.
    to_cnt_d       = '0;
    case (state_q)
      S_IDLE: begin
        if (coin_ok) begin
          credit_d = sum[2:0];
          state_d  = S_COLLECT;
        end else begin
          coin_reject_d = coin_in;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          coin_reject_d  = coin_in;
          refund_valid_d = 1'b1;
          refund_amt_d   = credit_q;
          state_d        = S_REFUND;
        end else if (confirm) begin
          coin_reject_d = coin_in;
          money_d       = credit_q;
          money_valid_d = 1'b1;
          state_d       = S_OFFER;
        end else if (coin_ok) begin
          credit_d = sum[2:0];
        end else begin
          coin_reject_d = coin_in;
          if (to_cnt_q == TO_LAST) begin
            refund_valid_d = 1'b1;
            refund_amt_d   = credit_q;
            state_d        = S_REFUND;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      S_OFFER: begin
        coin_reject_d = coin_in;
        if (vend_ack) begin
          credit_d      = 3'd0;
          money_valid_d = 1'b0;
          state_d       = S_IDLE;
        end else if (cancel) begin
          money_valid_d  = 1'b0;
          refund_valid_d = 1'b1;
          refund_amt_d   = credit_q;
          state_d        = S_REFUND;
        end
      end
      S_REFUND: begin
        coin_reject_d = coin_in;
        credit_d      = 3'd0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      credit_q       <= 3'd0;
      money_q        <= 3'd0;
      money_valid_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      refund_valid_q <= 1'b0;
      refund_amt_q   <= 3'd0;
      to_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      money_q        <= money_d;
      money_valid_q  <= money_valid_d;
      coin_reject_q  <= coin_reject_d;
      refund_valid_q <= refund_valid_d;
      refund_amt_q   <= refund_amt_d;
      to_cnt_q       <= to_cnt_d;
    end
  end

  assign money        = money_q;
  assign money_valid  = money_valid_q;
  assign credit       = credit_q;
  assign coin_reject  = coin_reject_q;
  assign refund_valid = refund_valid_q;
  assign refund_amt   = refund_amt_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// tb/tb_coin_accumulator.sv - directed scoreboard bench for coin_accumulator
// Expected output vectors are queued with each stimulus step and popped after the clock edge.
module tb_coin_accumulator;

  localparam logic [1:0] C1 = 2'b00, C2 = 2'b01, C5 = 2'b10, CX = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_in = 1'b0;
  logic [1:0] coin_val = 2'b00;
  logic       confirm = 1'b0;
  logic       cancel = 1'b0;
  logic       vend_ack = 1'b0;
  logic [2:0] money;
  logic       money_valid;
  logic [2:0] credit;
  logic       coin_reject;
  logic       refund_valid;
  logic [2:0] refund_amt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } sb_t;
  sb_t sb[$];

  logic [11:0] obs;
  assign obs = {money, money_valid, credit, coin_reject, refund_valid, refund_amt};

  coin_accumulator dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .coin_val(coin_val),
    .confirm(confirm), .cancel(cancel), .vend_ack(vend_ack),
    .money(money), .money_valid(money_valid), .credit(credit),
    .coin_reject(coin_reject), .refund_valid(refund_valid), .refund_amt(refund_amt)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] e(input logic [2:0] m, input logic mv, input logic [2:0] c,
                                    input logic rj, input logic rv, input logic [2:0] ra);
    return {m, mv, c, rj, rv, ra};
  endfunction

  task automatic push(input string tag, input logic [11:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic check();
    sb_t it;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: no expected entry, observed %h", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic step(input string tag, input logic ci, input logic [1:0] cv, input logic cf,
                      input logic cn, input logic va, input logic [11:0] exp);
    coin_in  = ci;
    coin_val = cv;
    confirm  = cf;
    cancel   = cn;
    vend_ack = va;
    push(tag, exp);
    @(posedge clk);
    #1;
    coin_in  = 1'b0;
    coin_val = 2'b00;
    confirm  = 1'b0;
    cancel   = 1'b0;
    vend_ack = 1'b0;
    check();
  endtask

  initial begin
    rst = 1'b0;
    #12;
    push("reset_state", e(0, 0, 0, 0, 0, 0));
    check();
    @(posedge clk);
    #1;
    rst = 1'b1;

    step("coin5",        1, C5, 0, 0, 0, e(0, 0, 5, 0, 0, 0));
    step("coin2",        1, C2, 0, 0, 0, e(0, 0, 7, 0, 0, 0));
    step("confirm",      0, C1, 1, 0, 0, e(7, 1, 7, 0, 0, 0));
    step("offer_hold",   0, C1, 0, 0, 0, e(7, 1, 7, 0, 0, 0));
    step("vend_ack",     0, C1, 0, 0, 1, e(7, 0, 0, 0, 0, 0));
    step("idle_confirm", 0, C1, 1, 0, 0, e(7, 0, 0, 0, 0, 0));

    step("c5_again",     1, C5, 0, 0, 0, e(7, 0, 5, 0, 0, 0));
    step("over_5",       1, C5, 0, 0, 0, e(7, 0, 5, 1, 0, 0));
    step("fill_2",       1, C2, 0, 0, 0, e(7, 0, 7, 0, 0, 0));
    step("over_1",       1, C1, 0, 0, 0, e(7, 0, 7, 1, 0, 0));
    step("cancel7",      0, C1, 0, 1, 0, e(7, 0, 7, 0, 1, 7));
    step("after_ref7",   0, C1, 0, 0, 0, e(7, 0, 0, 0, 0, 0));
    step("idle_invalid", 1, CX, 0, 0, 0, e(7, 0, 0, 1, 0, 0));
    step("idle_cancel",  0, C1, 0, 1, 0, e(7, 0, 0, 0, 0, 0));
    step("idle_ack",     0, C1, 0, 0, 1, e(7, 0, 0, 0, 0, 0));

    step("to_c1",        1, C1, 0, 0, 0, e(7, 0, 1, 0, 0, 0));
    step("to_c2",        1, C2, 0, 0, 0, e(7, 0, 3, 0, 0, 0));
    for (int i = 0; i < 19; i++) step("to_wait3", 0, C1, 0, 0, 0, e(7, 0, 3, 0, 0, 0));
    step("to_refund3",   0, C1, 0, 0, 0, e(7, 0, 3, 0, 1, 3));
    step("to_clear3",    0, C1, 0, 0, 0, e(7, 0, 0, 0, 0, 0));

    step("rs_c1",        1, C1, 0, 0, 0, e(7, 0, 1, 0, 0, 0));
    step("rs_c2",        1, C2, 0, 0, 0, e(7, 0, 3, 0, 0, 0));
    for (int i = 0; i < 19; i++) step("rs_wait", 0, C1, 0, 0, 0, e(7, 0, 3, 0, 0, 0));
    step("rs_coin_last", 1, C1, 0, 0, 0, e(7, 0, 4, 0, 0, 0));
    for (int i = 0; i < 5; i++) step("rs_wait4", 0, C1, 0, 0, 0, e(7, 0, 4, 0, 0, 0));
    step("all_three",    1, C1, 1, 1, 0, e(7, 0, 4, 1, 1, 4));
    step("after_ref4",   0, C1, 0, 0, 0, e(7, 0, 0, 0, 0, 0));

    step("o6_c5",        1, C5, 0, 0, 0, e(7, 0, 5, 0, 0, 0));
    step("o6_c1",        1, C1, 0, 0, 0, e(7, 0, 6, 0, 0, 0));
    step("o6_confirm",   0, C1, 1, 0, 0, e(6, 1, 6, 0, 0, 0));
    step("ack_cancel",   0, C1, 0, 1, 1, e(6, 0, 0, 0, 0, 0));
    step("ack_cancel_q", 0, C1, 0, 0, 0, e(6, 0, 0, 0, 0, 0));
    step("o6b_c5",       1, C5, 0, 0, 0, e(6, 0, 5, 0, 0, 0));
    step("o6b_c1",       1, C1, 0, 0, 0, e(6, 0, 6, 0, 0, 0));
    step("o6b_confirm",  0, C1, 1, 0, 0, e(6, 1, 6, 0, 0, 0));
    step("offer_coin",   1, C2, 0, 0, 0, e(6, 1, 6, 1, 0, 0));
    step("offer_cancel", 0, C1, 0, 1, 0, e(6, 0, 6, 0, 1, 6));
    step("after_ref6",   0, C1, 0, 0, 0, e(6, 0, 0, 0, 0, 0));

    step("r7_c5",        1, C5, 0, 0, 0, e(6, 0, 5, 0, 0, 0));
    step("r7_c2",        1, C2, 0, 0, 0, e(6, 0, 7, 0, 0, 0));
    step("r7_confirm",   0, C1, 1, 0, 0, e(7, 1, 7, 0, 0, 0));
    #3;
    rst = 1'b0;
    #1;
    push("async_reset", e(0, 0, 0, 0, 0, 0));
    check();
    @(posedge clk);
    @(posedge clk);
    #1;
    push("reset_hold", e(0, 0, 0, 0, 0, 0));
    check();
    rst = 1'b1;
    step("post_reset_c1", 1, C1, 0, 0, 0, e(0, 0, 1, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_accumulator.md
Name: coin_accumulator

Overview:
- Upstream stage of the food-vending controller `main`.
- Collects coin pulses from the coin slot into a 3-bit credit and rejects coins that would overflow the credit.
- On buyer confirm, offers the credit on `money[2:0]` with a valid/ack handshake to the vend controller.
- Refunds the credit on cancel or inactivity timeout.

Parameters:
- MAX_CREDIT, 7: highest credit the block holds; must be ≤ 7 to fit `money[2:0]`.
- TIMEOUT_CYC, 20: idle cycles in COLLECT before an automatic refund; must be ≥ 2.
- TO_W, 5: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin_in  in  1  one-cycle pulse: a coin is presented this cycle.
- coin_val  in  2  coin code: 00=1, 01=2, 10=5, 11=invalid.
- confirm  in  1  one-cycle pulse from the buyer: purchase with the current credit.
- cancel  in  1  one-cycle pulse from the buyer: abort and refund.
- vend_ack  in  1  from the vend controller: offered money consumed.
- money  out  3  credit offered to the vend controller.
- money_valid  out  1  `money` is valid; held until acknowledged.
- credit  out  3  running credit, for display.
- coin_reject  out  1  one-cycle pulse: the last coin was returned.
- refund_valid  out  1  one-cycle pulse: refund `refund_amt` now.
- refund_amt  out  3  refund amount; valid only while `refund_valid` is 1.

Behaviour:
- General: all outputs are registered. On `rst`=0, immediately: state=IDLE; `money`, `money_valid`, `credit`, `coin_reject`, `refund_valid`, `refund_amt`, timeout counter all 0.
- Coin acceptance: a coin is accepted iff `coin_val`≠11 and credit+value ≤ MAX_CREDIT; the addition is computed 4 bits wide.
  - Accepted coin: `credit` is updated on the next edge.
  - Rejected coin: `coin_reject`=1 for exactly one cycle, 1 cycle after `coin_in`; `credit` is unchanged.
- IDLE (credit=0):
  - Accepted coin → COLLECT.
  - `confirm`/`cancel` ignored.
  - Invalid coin → `coin_reject`; stay in IDLE.
- COLLECT:
  - Same-cycle priority: `cancel` > `confirm` > coin > timeout.
  - `cancel` → REFUND.
  - `confirm` → OFFER: `money`=`credit`, `money_valid`=1 on the next edge.
  - A coin arriving in the same cycle as `cancel` or `confirm` is rejected.
  - Timeout counter clears on any accepted coin and otherwise increments each cycle. When it reaches TIMEOUT_CYC-1, the next edge → REFUND.
- OFFER:
  - `money` and `money_valid` are held stable; every coin is rejected.
  - `vend_ack`=1 → IDLE; `credit`=0 and `money_valid`=0 on the next edge.
  - `cancel` without `vend_ack` → REFUND, `money_valid`=0.
  - `vend_ack` and `cancel` in the same cycle: `vend_ack` wins, no refund.
  - No timeout in OFFER.
- REFUND (lasts exactly one cycle):
  - `refund_valid`=1 and `refund_amt`=credit; coins rejected.
  - Next edge → IDLE with `credit`=0.
- Other rules:
  - `vend_ack` outside OFFER is ignored.
  - Reset asserted in any state discards credit without a refund pulse.
  - Credit never wraps; MAX_CREDIT is a hard ceiling.

Test Plan:
- Reset, then coins 5,2 then `confirm` → `credit` 5 then 7; `money`=7, `money_valid`=1 the cycle after `confirm`; `vend_ack` → `money_valid`=0, `credit`=0, state IDLE.
- Credit 5, coin 5 → `coin_reject` pulse, `credit` stays 5; then coin 2 → `credit`=7; coin 1 → rejected; `coin_val`=11 in IDLE → rejected, state stays IDLE.
- Credit 3, no activity for 20 cycles → `refund_valid` one cycle with `refund_amt`=3, then `credit`=0; a coin at cycle 19 restarts the count and no refund occurs.
- Credit 4, `cancel`+`confirm`+coin in the same cycle → REFUND with `refund_amt`=4, coin rejected, `money_valid` never asserts.
- OFFER with `money`=6: `vend_ack`+`cancel` together → no refund, IDLE; repeat with `cancel` alone → `refund_amt`=6, `money_valid`=0.
- Credit 7 in OFFER, `rst` driven low mid-cycle → all outputs 0 immediately without waiting for `clk`, no `refund_valid`; after release the block accepts coin 1 → `credit`=1.
